// File: rtl/fwd_result_pipe_pkg.sv
// Shared types and helpers for the result staging / forwarding pipe.
// Entry widths here set the default register-address and result widths.
package fwd_pipe_pkg;

  localparam int ENTRY_ADDR_W = 7;
  localparam int ENTRY_DATA_W = 128;
  localparam int STAGE_IDX_W  = 4;

  typedef struct packed {
    logic                    valid;
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [ENTRY_DATA_W-1:0] data;
  } fwd_entry_t;

  // Number of entries dropped by injections in one cycle
  function automatic logic [15:0] popcount16(input logic [15:0] vec);
    logic [15:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + 16'(vec[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/fwd_result_pipe_if.sv
// Bundle of injection, lookup, write-back and collision signals of one pipe.
interface fwd_result_pipe_if #(
  parameter int NUM_UNITS = 3,
  parameter int NUM_SRC   = 6,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 128
) ();
  import fwd_pipe_pkg::*;

  logic [NUM_UNITS-1:0]                  in_valid;
  logic [NUM_UNITS-1:0][ADDR_W-1:0]      in_addr;
  logic [NUM_UNITS-1:0][DATA_W-1:0]      in_data;
  logic                                  flush;
  logic [NUM_SRC-1:0][ADDR_W-1:0]        src_addr;
  logic [NUM_SRC-1:0]                    src_req;
  logic [NUM_SRC-1:0]                    fwd_hit;
  logic [NUM_SRC-1:0][DATA_W-1:0]        fwd_data;
  logic [NUM_SRC-1:0][STAGE_IDX_W-1:0]   fwd_stage;
  logic                                  wb_valid;
  logic [ADDR_W-1:0]                     wb_addr;
  logic [DATA_W-1:0]                     wb_data;
  logic                                  collision;
  logic [15:0]                           collision_cnt;

  modport master (
    output in_valid, in_addr, in_data, flush, src_addr, src_req,
    input  fwd_hit, fwd_data, fwd_stage, wb_valid, wb_addr, wb_data,
           collision, collision_cnt
  );

  modport slave (
    input  in_valid, in_addr, in_data, flush, src_addr, src_req,
    output fwd_hit, fwd_data, fwd_stage, wb_valid, wb_addr, wb_data,
           collision, collision_cnt
  );

endinterface

// File: rtl/fwd_result_pipe_lookup.sv
// One forwarding port: youngest valid entry with a matching address wins.
module fwd_lookup
  import fwd_pipe_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic                    req,
  input  logic [ENTRY_ADDR_W-1:0] addr,
  input  fwd_entry_t [DEPTH:1]    stages,
  input  fwd_entry_t              wb,
  output logic                    hit,
  output logic [ENTRY_DATA_W-1:0] data,
  output logic [STAGE_IDX_W-1:0]  stage
);

  fwd_entry_t [DEPTH+1:1] cand;

  assign cand = {wb, stages};

  // Scan oldest to youngest so the last match (lowest index) sticks
  always_comb begin
    hit   = 1'b0;
    data  = '0;
    stage = '0;
    for (int k = DEPTH + 1; k >= 1; k--) begin
      if (req && cand[k].valid && (cand[k].addr == addr)) begin
        hit   = 1'b1;
        data  = cand[k].data;
        stage = STAGE_IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_result_pipe.sv
// Result staging shift register with per-unit injection points, flush,
// collision accounting, write-back register and NUM_SRC forwarding ports.
module fwd_result_pipe
  import fwd_pipe_pkg::*;
#(
  parameter int                     DATA_W      = ENTRY_DATA_W,
  parameter int                     ADDR_W      = ENTRY_ADDR_W,
  parameter int                     DEPTH       = 7,
  parameter int                     NUM_UNITS   = 3,
  parameter logic [NUM_UNITS*8-1:0] UNIT_STAGE  = {8'd1, 8'd6, 8'd4},
  parameter int                     NUM_SRC     = 6,
  parameter int                     FLUSH_DEPTH = 2
) (
  input logic              clk,
  input logic              reset,
  fwd_result_pipe_if.slave bus
);

  fwd_entry_t [DEPTH:1] stage_reg;
  fwd_entry_t [DEPTH:1] stage_next;
  fwd_entry_t           wb_reg;
  logic [DEPTH:1]       coll_vec;
  logic                 collision_reg;
  logic [15:0]          collision_cnt_reg;
  logic [16:0]          cnt_sum;

  genvar gi, gj;

  generate
    if (ADDR_W != ENTRY_ADDR_W || DATA_W != ENTRY_DATA_W) begin : g_bad_width
      $error("fwd_result_pipe: ADDR_W/DATA_W must match fwd_pipe_pkg entry widths");
    end
    if (DEPTH + 1 >= (1 << STAGE_IDX_W) || FLUSH_DEPTH > DEPTH) begin : g_bad_depth
      $error("fwd_result_pipe: DEPTH/FLUSH_DEPTH out of range");
    end
    for (gi = 0; gi < NUM_UNITS; gi++) begin : g_unit_chk
      if (UNIT_STAGE[gi*8 +: 8] < 8'd1 || UNIT_STAGE[gi*8 +: 8] > 8'(DEPTH)) begin : g_range
        $error("fwd_result_pipe: UNIT_STAGE entry outside 1..DEPTH");
      end
      for (gj = gi + 1; gj < NUM_UNITS; gj++) begin : g_dup
        if (UNIT_STAGE[gi*8 +: 8] == UNIT_STAGE[gj*8 +: 8]) begin : g_dup_err
          $error("fwd_result_pipe: duplicate UNIT_STAGE values");
        end
      end
    end
  endgenerate

  generate
    for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
      fwd_entry_t shifted_w;
      fwd_entry_t next_w;
      logic       coll_w;

      if (gi == 1) begin : g_head
        assign shifted_w = '0;
      end else begin : g_body
        assign shifted_w = stage_reg[gi-1];
      end

      // Iterating high-to-low leaves the lowest-numbered injecting unit in place
      always_comb begin
        logic injected;
        next_w   = shifted_w;
        injected = 1'b0;
        for (int u = NUM_UNITS - 1; u >= 0; u--) begin
          if (bus.in_valid[u] && (UNIT_STAGE[u*8 +: 8] == 8'(gi))) begin
            next_w.valid = 1'b1;
            next_w.addr  = bus.in_addr[u];
            next_w.data  = bus.in_data[u];
            injected     = 1'b1;
          end
        end
        // A killed injection still displaced the older entry, so it counts
        coll_w = injected && shifted_w.valid;
        if (bus.flush && (gi <= FLUSH_DEPTH)) begin
          next_w = '0;
        end
      end

      assign stage_next[gi] = next_w;
      assign coll_vec[gi]   = coll_w;
    end
  endgenerate

  assign cnt_sum = {1'b0, collision_cnt_reg} + {1'b0, popcount16(16'(coll_vec))};

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg         <= '0;
      wb_reg            <= '0;
      collision_reg     <= 1'b0;
      collision_cnt_reg <= '0;
    end else begin
      stage_reg         <= stage_next;
      wb_reg            <= stage_reg[DEPTH];
      collision_reg     <= |coll_vec;
      collision_cnt_reg <= cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end
  end

  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_lookup
      fwd_lookup #(
        .DEPTH (DEPTH)
      ) u_lookup (
        .req    (bus.src_req[gi]),
        .addr   (bus.src_addr[gi]),
        .stages (stage_reg),
        .wb     (wb_reg),
        .hit    (bus.fwd_hit[gi]),
        .data   (bus.fwd_data[gi]),
        .stage  (bus.fwd_stage[gi])
      );
    end
  endgenerate

  assign bus.wb_valid      = wb_reg.valid;
  assign bus.wb_addr       = wb_reg.addr;
  assign bus.wb_data       = wb_reg.data;
  assign bus.collision     = collision_reg;
  assign bus.collision_cnt = collision_cnt_reg;

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: directed scenarios plus random traffic, all
// compared against a list-of-in-flight-results reference model.
module tb_fwd_result_pipe;
  import fwd_pipe_pkg::*;

  localparam int DEPTH       = 7;
  localparam int NUM_UNITS   = 3;
  localparam int NUM_SRC     = 6;
  localparam int FLUSH_DEPTH = 2;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 128;
  // unit 0 -> stage 1, unit 1 -> stage 6, unit 2 -> stage 4
  localparam logic [23:0] UNIT_STAGE = {8'd4, 8'd6, 8'd1};

  typedef struct {
    int                stage;   // 1..DEPTH, DEPTH+1 = write-back register
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } rec_t;

  logic clk = 1'b0;
  logic reset;
  rec_t recs[$];
  logic exp_coll;
  int   exp_cnt;
  int   n_checks = 0;
  int   n_pass = 0;
  bit   chk_en = 0;
  bit   verbose = 1;

  always #5 clk = ~clk;

  fwd_result_pipe_if #(
    .NUM_UNITS (NUM_UNITS),
    .NUM_SRC   (NUM_SRC),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) bus ();

  fwd_result_pipe #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .DEPTH       (DEPTH),
    .NUM_UNITS   (NUM_UNITS),
    .UNIT_STAGE  (UNIT_STAGE),
    .NUM_SRC     (NUM_SRC),
    .FLUSH_DEPTH (FLUSH_DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check_val(input string tag, input logic [DATA_W-1:0] obs,
                           input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic int unit_stage(input int u);
    return int'(UNIT_STAGE[u*8 +: 8]);
  endfunction

  // Results age by one stage per edge; an injection evicts whatever lands there
  task automatic model_step();
    rec_t      nq[$];
    rec_t      r;
    int        colls;
    bit [15:0] taken;
    if (reset) begin
      recs.delete();
      exp_coll = 1'b0;
      exp_cnt  = 0;
      return;
    end
    colls = 0;
    taken = '0;
    foreach (recs[i]) begin
      if (recs[i].stage <= DEPTH) begin
        r = recs[i];
        r.stage = r.stage + 1;
        nq.push_back(r);
      end
    end
    for (int u = 0; u < NUM_UNITS; u++) begin
      if (bus.in_valid[u] && !taken[unit_stage(u)]) begin
        int s;
        s = unit_stage(u);
        taken[s] = 1'b1;
        for (int i = nq.size() - 1; i >= 0; i--) begin
          if (nq[i].stage == s) begin
            nq.delete(i);
            colls++;
          end
        end
        r.stage = s;
        r.addr  = bus.in_addr[u];
        r.data  = bus.in_data[u];
        nq.push_back(r);
      end
    end
    if (bus.flush) begin
      for (int i = nq.size() - 1; i >= 0; i--) begin
        if (nq[i].stage <= FLUSH_DEPTH) nq.delete(i);
      end
    end
    recs     = nq;
    exp_coll = (colls > 0);
    exp_cnt  = (exp_cnt + colls > 65535) ? 65535 : exp_cnt + colls;
  endtask

  task automatic compare_all();
    logic              ev;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    int                best;
    ev = 1'b0; ea = '0; ed = '0;
    foreach (recs[i]) begin
      if (recs[i].stage == DEPTH + 1) begin
        ev = 1'b1; ea = recs[i].addr; ed = recs[i].data;
      end
    end
    check_val("wb_valid", DATA_W'(bus.wb_valid), DATA_W'(ev));
    check_val("wb_addr", DATA_W'(bus.wb_addr), DATA_W'(ea));
    check_val("wb_data", bus.wb_data, ed);
    check_val("collision", DATA_W'(bus.collision), DATA_W'(exp_coll));
    check_val("collision_cnt", DATA_W'(bus.collision_cnt), DATA_W'(exp_cnt));
    for (int j = 0; j < NUM_SRC; j++) begin
      best = 0; ed = '0;
      if (bus.src_req[j]) begin
        foreach (recs[i]) begin
          if (recs[i].addr == bus.src_addr[j] && (best == 0 || recs[i].stage < best)) begin
            best = recs[i].stage; ed = recs[i].data;
          end
        end
      end
      check_val($sformatf("fwd_hit[%0d]", j), DATA_W'(bus.fwd_hit[j]), DATA_W'(best != 0));
      check_val($sformatf("fwd_data[%0d]", j), bus.fwd_data[j], ed);
      check_val($sformatf("fwd_stage[%0d]", j), DATA_W'(bus.fwd_stage[j]), DATA_W'(best));
    end
  endtask

  // Called just after a negedge with inputs already driven
  task automatic cycle();
    if (verbose && (bus.in_valid != '0 || bus.flush || reset))
      $display("txn t=%0t rst=%b valid=%b flush=%b addr=%0d/%0d/%0d", $time, reset,
               bus.in_valid, bus.flush, bus.in_addr[0], bus.in_addr[1], bus.in_addr[2]);
    if (chk_en) begin
      #1;
      compare_all();
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.in_valid = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic set_src(input logic [ADDR_W-1:0] a);
    for (int j = 0; j < NUM_SRC; j++) begin
      bus.src_req[j]  = 1'b1;
      bus.src_addr[j] = a;
    end
  endtask

  task automatic rand_inputs(input bit with_flush);
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.in_addr[u] = ADDR_W'($urandom_range(0, 15));
      bus.in_data[u] = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.in_valid = NUM_UNITS'($urandom);
    bus.flush    = with_flush && ($urandom_range(0, 7) == 0);
    for (int j = 0; j < NUM_SRC; j++) begin
      bus.src_req[j]  = ($urandom_range(0, 3) != 0);
      bus.src_addr[j] = ADDR_W'($urandom_range(0, 15));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = '1;
    bus.flush = 1'b0;
    cycle();
    reset = 1'b0;
    idle();
  endtask

  task automatic inject(input int u, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.in_valid    = '0;
    bus.in_valid[u] = 1'b1;
    bus.in_addr[u]  = a;
    bus.in_data[u]  = d;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    bus.in_addr = '0;
    bus.in_data = '0;
    set_src('0);
    @(negedge clk);
    do_reset();
    chk_en = 1;
    #1;
    check_val("rst_wb_valid", DATA_W'(bus.wb_valid), '0);
    check_val("rst_cnt", DATA_W'(bus.collision_cnt), '0);

    // Single injection at stage 4 travels to write-back
    set_src(7'd5);
    inject(2, 7'd5, 128'hA5A5);
    cycle();
    idle();
    repeat (4) cycle();
    #1;
    check_val("single_wb_valid", DATA_W'(bus.wb_valid), DATA_W'(1));
    check_val("single_wb_addr", DATA_W'(bus.wb_addr), DATA_W'(5));
    check_val("single_wb_data", bus.wb_data, 128'hA5A5);
    check_val("single_fwd_stage", DATA_W'(bus.fwd_stage[0]), DATA_W'(DEPTH + 1));
    cycle();

    // Stage-4 injection overwrites the entry arriving from stage 3
    do_reset();
    set_src(7'd3);
    bus.src_addr[5] = 7'd9;
    inject(0, 7'd3, 128'h33);
    cycle();
    idle();
    cycle();
    cycle();
    inject(2, 7'd9, 128'h99);
    cycle();
    idle();
    #1;
    check_val("coll_pulse", DATA_W'(bus.collision), DATA_W'(1));
    check_val("coll_cnt", DATA_W'(bus.collision_cnt), DATA_W'(1));
    check_val("coll_lost", DATA_W'(bus.fwd_hit[0]), '0);
    repeat (5) cycle();

    // Younger entry at stage 2 beats older one at stage 6
    do_reset();
    set_src(7'd7);
    inject(0, 7'd7, 128'h2);
    cycle();
    inject(1, 7'd7, 128'h1);
    cycle();
    idle();
    #1;
    check_val("prio_data", bus.fwd_data[0], 128'h2);
    check_val("prio_stage", DATA_W'(bus.fwd_stage[0]), DATA_W'(2));
    repeat (7) cycle();

    // Flush kills stage 1/2 arrivals, stage 3->4 survives
    do_reset();
    set_src(7'd20);
    bus.src_addr[1] = 7'd21;
    bus.src_addr[2] = 7'd4;
    inject(0, 7'd20, 128'h20);
    cycle();
    idle();
    cycle();
    inject(0, 7'd21, 128'h21);
    cycle();
    inject(0, 7'd4, 128'h4);
    bus.flush = 1'b1;
    cycle();
    idle();
    #1;
    check_val("flush_inj_killed", DATA_W'(bus.fwd_hit[2]), '0);
    check_val("flush_s2_killed", DATA_W'(bus.fwd_hit[1]), '0);
    check_val("flush_survivor", DATA_W'(bus.fwd_stage[0]), DATA_W'(4));
    repeat (4) cycle();
    #1;
    check_val("flush_wb_addr", DATA_W'(bus.wb_addr), DATA_W'(20));
    cycle();

    // Reset while entries are in flight
    do_reset();
    repeat (4) begin
      rand_inputs(0);
      bus.in_valid = '1;
      cycle();
    end
    do_reset();
    repeat (8) begin
      #1;
      check_val("rst_mid_wb", DATA_W'(bus.wb_valid), '0);
      cycle();
    end
    #1;
    check_val("rst_mid_cnt", DATA_W'(bus.collision_cnt), '0);

    // Random traffic with occasional flush and reset
    for (int n = 0; n < 400; n++) begin
      rand_inputs(1);
      reset = ($urandom_range(0, 99) == 0);
      cycle();
    end
    reset = 1'b0;

    // Saturate the collision counter: two collisions per cycle once full
    do_reset();
    verbose = 0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      bus.in_addr[u] = ADDR_W'(u + 1);
      bus.in_data[u] = DATA_W'(u + 1);
    end
    bus.in_valid = '1;
    for (int j = 0; j < NUM_SRC; j++) bus.src_req[j] = 1'b0;
    repeat (32800) cycle();
    #1;
    check_val("sat_cnt", DATA_W'(bus.collision_cnt), DATA_W'(16'hFFFF));
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
